counter_serializer: RTL and testbench
=====================================

# counter_serializer

Downstream consumer of the 8-bit counter output produced by the design's `top` block. Samples the counter every cycle, queues each new value in a small FIFO and transmits it as a UART-style frame on a single serial line, so the counter can be observed on a pin or by a bench monitor. Values that arrive while the FIFO is full are dropped and counted.

## Interface
- CLKS_PER_BIT, 4, cycles per serial bit; legal range 1..255
- FIFO_DEPTH, 4, queue entries; power of two, minimum 2
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- inCounter  in  8  counter value from upstream stage
- inEnable  in  1  1 = sample inCounter this cycle
- outTx  out  1  serial line; idles high
- outBusy  out  1  1 while a frame is on the line
- outLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- outDropped  out  8  saturating count of values lost to a full FIFO

## Operation
- Change detect: `prevValue` (8 b) and `prevValid` (1 b).
  - Edge with inEnable=1: push request if prevValid=0 or inCounter≠prevValue. Then prevValue←inCounter, prevValid←1.
  - Edge with inEnable=0: no push; prevValid←0. The first sample after re-enable is always pushed.
- FIFO:
  - Push is accepted if not full. If full, the value is discarded and outDropped increments, saturating at 255.
  - Pop happens only when the FSM is IDLE and the FIFO is not empty.
  - Push and pop on the same edge: both take effect and the level is unchanged. This applies when full too, so the push is accepted and not dropped.
- Shifter FSM states: IDLE, START, DATA, STOP.
  - IDLE: outTx=1. If FIFO not empty, pop into an 8-bit shift register, clear bit and cycle counters, go to START.
  - START: outTx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: outTx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles. After 8 bits, go to STOP.
  - STOP: outTx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- outBusy=1 in START, DATA and STOP; 0 in IDLE.
- outTx is registered and must be glitch-free.

## Timing
- Reset values: outTx=1, outBusy=0, outLevel=0, outDropped=0, prevValid=0, FSM=IDLE, FIFO empty.
- Inputs are ignored on any edge where rst=1.
- Latency:
  - A new value present before edge N is pushed at N, so outLevel rises after N when the FIFO was empty.
  - The pop happens at N+1; outTx=0 and outBusy=1 are visible after N+1.
- Frame length: 10×CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
- Back-to-back frames are separated by exactly one IDLE cycle with outTx=1.
- Reset mid-frame: the frame is aborted, outTx=1 on the next cycle, the FIFO is emptied and outDropped is cleared.
- Wrap-around: a 255→0 transition is an ordinary change and is pushed.

## Test plan
- Reset, then inCounter=100 (0x64) held with inEnable=1, CLKS_PER_BIT=4 -> exactly one frame:
  - start 0 for 4 cycles;
  - data bits 0,0,1,0,0,1,1,0, 4 cycles each;
  - stop 1 for 4 cycles;
  - outLevel returns to 0 and outBusy drops after 40 cycles.
- Same stimulus held 200 cycles -> no second frame; outTx stays 1 after the first frame; outDropped=0.
- inCounter=0..9 incrementing each cycle, FIFO_DEPTH=4 -> outLevel peaks at 4; frames carry 0,1,2,3,4 in order, each separated by one idle cycle; outDropped=5.
- Value incrementing every cycle for 1000 cycles -> outDropped saturates at 255 and never wraps.
- Constant 7, inEnable=0 for 3 cycles, then 1 -> a second frame carrying 7 follows the first.
- Assert rst for one cycle in the middle of DATA -> outTx=1, outBusy=0, outLevel=0 on the next cycle. After release, the current inCounter value is retransmitted as a fresh frame.

Source files
------------

// File: rtl/counter_serializer.sv
// counter_serializer: queues each changed counter sample in a FIFO and sends it as an 8N1 serial frame
module counter_serializer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  inCounter,
   input  logic                        inEnable,
   output logic                        outTx,
   output logic                        outBusy,
   output logic [$clog2(FIFO_DEPTH):0] outLevel,
   output logic [7:0]                  outDropped
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state_q, state_d;
   logic [7:0]    prev_value_q;
   logic          prev_valid_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic [7:0]    dropped_q, dropped_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    clk_cnt_q, clk_cnt_d;
   logic          tx_q, tx_d;
   logic          push_req, full, pop, push, drop, bit_done;
   assign push_req = inEnable && (!prev_valid_q || inCounter != prev_value_q);
   assign full     = level_q == DEPTH_L;
   assign pop      = state_q == IDLE && level_q != '0;
   // a pop on the same edge frees a slot, so a push into a full FIFO is still accepted
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign bit_done = clk_cnt_q == LAST_CLK;
   assign level_d   = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign dropped_d = (drop && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      clk_cnt_d = bit_done ? '0 : clk_cnt_q + 8'd1;
      tx_d      = tx_q;
      case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            if (pop) begin
               state_d   = START;
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = '0;
               tx_d      = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               state_d   = bit_cnt_q == 3'd7 ? STOP : DATA;
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               tx_d      = bit_cnt_q == 3'd7 ? 1'b1 : shift_q[1];
            end
         end
         STOP: begin
            if (bit_done) begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_value_q <= '0;
         prev_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         dropped_q    <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         clk_cnt_q    <= '0;
         tx_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         if (inEnable) prev_value_q <= inCounter;
         prev_valid_q <= inEnable;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q      <= level_d;
         dropped_q    <= dropped_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         clk_cnt_q    <= clk_cnt_d;
         tx_q         <= tx_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= inCounter;
   end
   assign outTx      = tx_q;
   assign outBusy    = state_q != IDLE;
   assign outLevel   = level_q;
   assign outDropped = dropped_q;
endmodule

// File: tb/tb_counter_serializer.sv
// tb_counter_serializer: directed stimulus against a frame-timeline model plus a serial decoder on outTx
module tb_counter_serializer;
   localparam int CPB = 4;
   localparam int DEPTH = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] inCounter = '0;
   logic       inEnable = 1'b0;
   logic       outTx, outBusy;
   logic [2:0] outLevel;
   logic [7:0] outDropped;
   int checks = 0;
   int failures = 0;
   // model: pending values, position inside the current frame (-1 = line idle), byte on the line
   logic [7:0] mq[$];
   int         m_pos = -1;
   logic [7:0] m_byte = '0;
   logic [7:0] m_prev = '0;
   bit         m_pv = 0;
   int         m_drop = 0;
   // observations of the DUT
   logic [7:0] rx_q[$];
   int busy_cycles = 0, peak = 0, gap_min = 1000, gap_max = 0, idle_run = 0;
   bit seen_frame = 0, last_busy = 0;
   bit rx_active = 0;
   int rx_cnt = 0;
   logic [7:0] rx_byte = '0;

   counter_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .inCounter(inCounter), .inEnable(inEnable),
      .outTx(outTx), .outBusy(outBusy), .outLevel(outLevel), .outDropped(outDropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   initial forever begin
      int k;
      bit exp_tx, req, full, pop;
      @(negedge clk);
      k = m_pos / CPB;
      exp_tx = m_pos < 0 ? 1'b1 : k == 0 ? 1'b0 : k == 9 ? 1'b1 : m_byte[k-1];
      check("tx", int'(outTx), int'(exp_tx));
      check("busy", int'(outBusy), int'(m_pos >= 0));
      check("level", int'(outLevel), mq.size());
      check("dropped", int'(outDropped), m_drop);
      if (outBusy) busy_cycles++;
      if (int'(outLevel) > peak) peak = int'(outLevel);
      if (outBusy && !last_busy) begin
         if (seen_frame) begin
            if (idle_run < gap_min) gap_min = idle_run;
            if (idle_run > gap_max) gap_max = idle_run;
         end
         seen_frame = 1;
      end
      idle_run = outBusy ? 0 : idle_run + 1;
      last_busy = outBusy;
      if (rst) rx_active = 0;
      else if (!rx_active && !outTx) begin
         rx_active = 1;
         rx_cnt = 0;
      end
      if (rx_active) begin
         if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_byte[rx_cnt/CPB-1] = outTx;
         if (rx_cnt == 9 * CPB + CPB / 2) check("stop_bit", int'(outTx), 1);
         if (rx_cnt == 10 * CPB - 1) begin
            rx_q.push_back(rx_byte);
            rx_active = 0;
         end
         rx_cnt++;
      end
      // advance the model over the coming rising edge
      if (rst) begin
         mq.delete();
         m_pos = -1;
         m_pv = 0;
         m_drop = 0;
      end else begin
         req = inEnable && (!m_pv || inCounter != m_prev);
         full = mq.size() == DEPTH;
         pop = m_pos < 0 && mq.size() > 0;
         if (m_pos >= 0) m_pos = (m_pos + 1 == 10 * CPB) ? -1 : m_pos + 1;
         if (pop) begin
            m_byte = mq.pop_front();
            m_pos = 0;
         end
         if (req) begin
            if (!full || pop) mq.push_back(inCounter);
            else if (m_drop < 255) m_drop++;
         end
         m_prev = inEnable ? inCounter : m_prev;
         m_pv = inEnable;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(1);
      rst = 1'b1;
      inEnable = 1'b0;
      inCounter = '0;
      tick(2);
      rst = 1'b0;
      rx_q.delete();
      busy_cycles = 0;
      peak = 0;
      gap_min = 1000;
      gap_max = 0;
      seen_frame = 0;
      idle_run = 0;
   endtask

   initial begin
      do_reset();
      check("reset_tx", int'(outTx), 1);
      check("reset_level", int'(outLevel), 0);
      // one constant value: exactly one frame carrying 0x64
      inEnable = 1'b1;
      inCounter = 8'd100;
      tick(200);
      check("t1_frames", rx_q.size(), 1);
      if (rx_q.size() > 0) check("t1_byte", int'(rx_q[0]), 100);
      check("t1_busy_len", busy_cycles, 40);
      check("t1_dropped", int'(outDropped), 0);
      check("t1_idle_tx", int'(outTx), 1);
      // ramp 0..9 into a 4-deep FIFO
      do_reset();
      for (int i = 0; i < 10; i++) begin
         inEnable = 1'b1;
         inCounter = 8'(i);
         tick(1);
      end
      tick(250);
      check("t2_peak", peak, 4);
      check("t2_frames", rx_q.size(), 5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++) check("t2_byte", int'(rx_q[i]), i);
      check("t2_dropped", int'(outDropped), 5);
      check("t2_gap_min", gap_min, 1);
      check("t2_gap_max", gap_max, 1);
      // continuous change: drop counter saturates
      do_reset();
      inEnable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         inCounter = 8'(i);
         tick(1);
      end
      check("t3_dropped_sat", int'(outDropped), 255);
      // re-enable retransmits an unchanged value
      do_reset();
      check("t4_dropped_cleared", int'(outDropped), 0);
      inEnable = 1'b1;
      inCounter = 8'd7;
      tick(5);
      inEnable = 1'b0;
      tick(3);
      inEnable = 1'b1;
      tick(150);
      check("t4_frames", rx_q.size(), 2);
      for (int i = 0; i < 2 && i < rx_q.size(); i++) check("t4_byte", int'(rx_q[i]), 7);
      // reset in the middle of the data bits
      do_reset();
      inEnable = 1'b1;
      inCounter = 8'h5A;
      tick(14);
      check("t5_busy_before", int'(outBusy), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t5_tx_after", int'(outTx), 1);
      check("t5_busy_after", int'(outBusy), 0);
      check("t5_level_after", int'(outLevel), 0);
      tick(60);
      check("t5_frames", rx_q.size(), 1);
      if (rx_q.size() > 0) check("t5_byte", int'(rx_q[0]), 8'h5A);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
